// File: rtl/nanov_store_periph_pkg.sv
// Shared definitions for the nanoV store-port peripheral block.
//   PERIPH_BASE_HI : address bits [31:24] that select the peripheral region
//   REG_*          : register offsets taken from address bits [3:2]
//   tx_state_e     : UART transmitter state encoding
//   bit_rev32      : undoes the CPU's bit-reversed data bus ordering
package nanoV_periph_pkg;

    localparam logic [7:0] PERIPH_BASE_HI = 8'h10;

    localparam logic [1:0] REG_GPIO_OUT = 2'd0;
    localparam logic [1:0] REG_UART_TX  = 2'd1;
    localparam logic [1:0] REG_GPIO_SET = 2'd2;
    localparam logic [1:0] REG_GPIO_CLR = 2'd3;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    function automatic logic [31:0] bit_rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/nanov_store_periph_if.sv
// CPU store-port bus as seen by the peripheral block.
//   data_in       : shared 32-bit data bus (address normal order, data bit-reversed)
//   store_addr_in : one-cycle strobe, data_in holds a store address
//   store_data_in : one-cycle strobe, data_in holds store data
interface nanov_store_periph_if;
    logic [31:0] data_in;
    logic        store_addr_in;
    logic        store_data_in;

    modport master (output data_in, output store_addr_in, output store_data_in);
    modport slave  (input  data_in, input  store_addr_in, input  store_data_in);
endinterface

// File: rtl/nanov_store_periph_fifo.sv
// Synchronous circular FIFO with an extra pointer bit for full/empty.
//   clk, rst  : clock, asynchronous active-high reset
//   push_i    : write din_i (accepted when not full, or when popping same cycle)
//   pop_i     : advance read pointer (ignored when empty)
//   din_i     : write data
//   dout_o    : head-of-queue data (combinational read)
//   full_o    : all DEPTH entries occupied
//   empty_o   : no entries
module nanoV_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, rptr_q;
    logic             do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    // Same slot, opposite wrap bit: writer is a full lap ahead.
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    // A pop frees the head slot this edge, so a push into a full FIFO still fits.
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/nanov_store_periph.sv
// Write-only peripheral behind the nanoV CPU store port: pairs address and
// data strobes, decodes the 0x10xx_xxxx region, drives a GPIO register and an
// 8N1 UART transmitter fed by a small FIFO.
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : CPU store-port bus (slave side)
//   gpio_out   : GPIO output register
//   uart_tx    : registered serial output, idle high
//   uart_busy  : frame in flight or bytes queued
//   fifo_full  : TX FIFO full
//   overflow   : sticky, a UART byte was dropped
module nanov_store_periph import nanoV_periph_pkg::*; #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int GPIO_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    nanov_store_periph_if.slave   bus,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    output logic                  uart_tx,
    output logic                  uart_busy,
    output logic                  fifo_full,
    output logic                  overflow
);
    localparam int            BW        = $clog2(CLK_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

    logic [31:0]           addr_q;
    logic                  addr_valid_q;
    logic [31:0]           wdata;
    logic [1:0]            reg_sel;
    logic                  wr_en, push;
    logic [GPIO_WIDTH-1:0] gpio_q, gpio_d, wbits;
    logic                  overflow_q;
    logic                  fifo_pop, fifo_empty;
    logic [7:0]            fifo_dout;
    tx_state_e             state_q, state_d;
    logic [BW-1:0]         baud_q, baud_d;
    logic [2:0]            bit_q, bit_d;
    logic [7:0]            shift_q, shift_d;
    logic                  tx_q, tx_d;
    logic                  baud_end;
    logic                  unused_bits;

    assign wdata   = bit_rev32(bus.data_in);
    assign wbits   = wdata[GPIO_WIDTH-1:0];
    assign reg_sel = addr_q[3:2];
    // Data only acts when it has an address to pair with, and only in-region.
    assign wr_en   = bus.store_data_in && addr_valid_q && (addr_q[31:24] == PERIPH_BASE_HI);
    assign push    = wr_en && (reg_sel == REG_UART_TX);
    assign unused_bits = ^{addr_q[23:4], addr_q[1:0], wdata};

    // A simultaneous address strobe wins over the data strobe's clear, so the
    // data pairs with the old address and the new address stays latched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q       <= '0;
            addr_valid_q <= 1'b0;
        end else if (bus.store_addr_in) begin
            addr_q       <= bus.data_in;
            addr_valid_q <= 1'b1;
        end else if (bus.store_data_in) begin
            addr_valid_q <= 1'b0;
        end
    end

    always_comb begin
        gpio_d = gpio_q;
        if (wr_en) begin
            case (reg_sel)
                REG_GPIO_OUT: gpio_d = wbits;
                REG_GPIO_SET: gpio_d = gpio_q | wbits;
                REG_GPIO_CLR: gpio_d = gpio_q & ~wbits;
                default:      gpio_d = gpio_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpio_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            gpio_q <= gpio_d;
            if (push && fifo_full && !fifo_pop) overflow_q <= 1'b1;
        end
    end

    nanoV_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (fifo_pop),
        .din_i   (wdata[7:0]),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign baud_end = (baud_q == BAUD_LAST);

    // tx_d is the line level for the bit that starts on this edge.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        fifo_pop = 1'b0;
        case (state_q)
            TX_IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    state_d  = TX_START;
                    tx_d     = 1'b0;
                end
            end
            TX_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = TX_DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            TX_DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = TX_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            TX_STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when bytes are queued.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        state_d  = TX_START;
                        tx_d     = 1'b0;
                    end else begin
                        state_d = TX_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= TX_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign gpio_out  = gpio_q;
    assign uart_tx   = tx_q;
    assign uart_busy = (state_q != TX_IDLE) || !fifo_empty;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_nanov_store_periph.sv
// Bench for nanov_store_periph: directed scenarios plus random strobes, with a
// queue-based behavioural model checked every cycle.
module tb_nanov_store_periph;
    localparam int CD    = 4;
    localparam int DEPTH = 4;
    localparam int GW    = 8;
    localparam int FRAME = 10 * CD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [GW-1:0] gpio_out;
    logic uart_tx, uart_busy, fifo_full, overflow;

    nanov_store_periph_if bus();

    nanov_store_periph #(
        .CLK_DIV    (CD),
        .FIFO_DEPTH (DEPTH),
        .GPIO_WIDTH (GW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .gpio_out  (gpio_out),
        .uart_tx   (uart_tx),
        .uart_busy (uart_busy),
        .fifo_full (fifo_full),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    // Behavioural model: queue of waiting bytes, a frame described by its
    // byte and the number of clocks elapsed since it started.
    logic [GW-1:0] m_gpio;
    logic [31:0]   m_addr, m_w;
    bit            m_av, m_ovf, m_fact, m_pop, m_push;
    logic [7:0]    m_q[$];
    logic [7:0]    m_fbyte, m_pb, m_head;
    int            m_fcnt, m_n;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_gpio = '0; m_addr = '0; m_av = 1'b0; m_ovf = 1'b0;
            m_q.delete(); m_fact = 1'b0; m_fcnt = 0; m_fbyte = '0;
        end else begin
            m_pop  = (m_q.size() != 0) && (!m_fact || m_fcnt == FRAME - 1);
            m_push = 1'b0;
            m_pb   = '0;
            m_head = '0;
            if (bus.store_data_in && m_av) begin
                m_w = rev32(bus.data_in);
                if (m_addr[31:24] == 8'h10) begin
                    case (m_addr[3:2])
                        2'd0: m_gpio = m_w[GW-1:0];
                        2'd1: begin m_push = 1'b1; m_pb = m_w[7:0]; end
                        2'd2: m_gpio = m_gpio | m_w[GW-1:0];
                        default: m_gpio = m_gpio & ~m_w[GW-1:0];
                    endcase
                end
                m_av = 1'b0;
            end
            if (bus.store_addr_in) begin
                m_addr = bus.data_in;
                m_av   = 1'b1;
            end
            m_n = m_q.size();
            if (m_pop) m_head = m_q.pop_front();
            if (m_push) begin
                if (m_n < DEPTH || m_pop) m_q.push_back(m_pb);
                else m_ovf = 1'b1;
            end
            if (m_fact && m_fcnt != FRAME - 1) m_fcnt++;
            else if (m_pop) begin m_fact = 1'b1; m_fcnt = 0; m_fbyte = m_head; end
            else m_fact = 1'b0;
        end
    end

    function automatic logic exp_tx();
        if (!m_fact) return 1'b1;
        if (m_fcnt < CD) return 1'b0;
        if (m_fcnt < 9 * CD) return m_fbyte[m_fcnt / CD - 1];
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_gpio", 32'(gpio_out), 32'(m_gpio));
            chk("m_uart_tx", 32'(uart_tx), 32'(exp_tx()));
            chk("m_busy", 32'(uart_busy), 32'(m_fact || m_q.size() != 0));
            chk("m_full", 32'(fifo_full), 32'(m_q.size() == DEPTH));
            chk("m_overflow", 32'(overflow), 32'(m_ovf));
        end
    end

    // Called at a falling edge; returns at the next falling edge.
    task automatic tick(input logic a, input logic d, input logic [31:0] v);
        bus.store_addr_in = a;
        bus.store_data_in = d;
        bus.data_in       = v;
        @(posedge clk);
        @(negedge clk);
        bus.store_addr_in = 1'b0;
        bus.store_data_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b0, 32'h0);
    endtask

    task automatic store(input logic [31:0] a, input logic [7:0] d);
        tick(1'b1, 1'b0, a);
        tick(1'b0, 1'b1, rev32({24'h0, d}));
    endtask

    logic [7:0] rx;

    initial begin
        bus.data_in = '0;
        bus.store_addr_in = 1'b0;
        bus.store_data_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_gpio", 32'(gpio_out), 32'h0);
        chk("rst_tx", 32'(uart_tx), 32'h1);
        chk("rst_busy", 32'(uart_busy), 32'h0);
        chk("rst_full", 32'(fifo_full), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);
        rst = 1'b0;
        chk_en = 1'b1;

        // GPIO write with the raw bit-reversed bus value
        tick(1'b1, 1'b0, 32'h1000_0000);
        tick(1'b0, 1'b1, 32'hA500_0000);
        chk("gpio_a5", 32'(gpio_out), 32'hA5);

        store(32'h1000_0000, 8'h0F);
        store(32'h1000_0008, 8'hF0);
        chk("gpio_set", 32'(gpio_out), 32'hFF);
        store(32'h1000_000C, 8'h03);
        chk("gpio_clr", 32'(gpio_out), 32'hFC);

        // Single UART frame
        store(32'h1000_0004, 8'h55);
        chk("tx_before_pop", 32'(uart_tx), 32'h1);
        idle(1);
        chk("tx_start", 32'(uart_tx), 32'h0);
        for (int i = 0; i < 8; i++) begin
            idle(CD);
            rx[i] = uart_tx;
        end
        chk("tx_byte", 32'(rx), 32'h55);
        idle(CD);
        chk("tx_stop", 32'(uart_tx), 32'h1);
        idle(CD - 1);
        chk("busy_end", 32'(uart_busy), 32'h1);
        idle(1);
        chk("busy_done", 32'(uart_busy), 32'h0);

        // Fill the FIFO, then overflow it
        for (int i = 0; i < 5; i++) store(32'h1000_0004, 8'h11 + 8'(i));
        chk("fill_full", 32'(fifo_full), 32'h1);
        chk("fill_ovf", 32'(overflow), 32'h0);
        store(32'h1000_0004, 8'h66);
        chk("ovf_set", 32'(overflow), 32'h1);
        idle(5 * FRAME);
        chk("drain_busy", 32'(uart_busy), 32'h0);

        // Ignored stores
        tick(1'b0, 1'b1, rev32(32'h33));
        chk("no_addr", 32'(gpio_out), 32'hFC);
        store(32'h0000_0004, 8'h77);
        chk("out_region_busy", 32'(uart_busy), 32'h0);
        store(32'h0000_0000, 8'h33);
        chk("out_region_gpio", 32'(gpio_out), 32'hFC);
        tick(1'b1, 1'b0, 32'h1000_0000);
        tick(1'b1, 1'b1, rev32(32'h3C));
        chk("both_strobes", 32'(gpio_out), 32'h3C);
        tick(1'b0, 1'b1, rev32(32'h99));
        chk("new_addr_latched", 32'(gpio_out), 32'h3C);

        // Reset in the middle of a data bit
        store(32'h1000_0004, 8'hA7);
        idle(1 + CD + 2);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_tx", 32'(uart_tx), 32'h1);
        chk("mid_rst_gpio", 32'(gpio_out), 32'h0);
        chk("mid_rst_busy", 32'(uart_busy), 32'h0);
        chk("mid_rst_ovf", 32'(overflow), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        store(32'h1000_0000, 8'h5A);
        chk("post_rst_gpio", 32'(gpio_out), 32'h5A);
        store(32'h1000_0004, 8'hC3);
        idle(FRAME + 2);

        // Random strobes
        for (int i = 0; i < 500; i++) begin
            logic a, d;
            logic [31:0] v;
            a = ($urandom % 3) == 0;
            d = ($urandom % 3) == 0;
            v = $urandom;
            if (a && ($urandom % 4) != 0) v[31:24] = 8'h10;
            if (a && ($urandom % 2) != 0) v[3:2] = 2'd1;
            tick(a, d, v);
        end
        idle(6 * FRAME);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
